// File: rtl/alu_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_resp                                                        |
// | Purpose  : Two-stage valid/ready ALU (ADD/SUB/AND/OR) with a consume count.|
// |            Define ALU_RESP_FLAGS_EN to add registered zero/carry outputs.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_resp #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   input  logic [1:0]   sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [31:0]  op_count
`ifdef ALU_RESP_FLAGS_EN
   ,
   output logic         zero,
   output logic         carry
`endif
);

   localparam logic [1:0] c_sel_add = 2'b00;
   localparam logic [1:0] c_sel_sub = 2'b01;
   localparam logic [1:0] c_sel_and = 2'b10;

   logic         r_s1_valid;
   logic [N-1:0] r_s1_a;
   logic [N-1:0] r_s1_b;
   logic [1:0]   r_s1_sel;
   logic         r_s2_valid;
   logic [N-1:0] r_result;
   logic [31:0]  r_op_count;

   logic         w_consume;
   logic         w_xfer;
   logic         w_accept;
   logic [N-1:0] w_calc;

   assign w_consume = r_s2_valid & out_ready;
   // S2 frees up in the same edge it is consumed, so S1 can advance into it.
   assign w_xfer    = r_s1_valid & (~r_s2_valid | w_consume);
   assign in_ready  = ~r_s1_valid | w_xfer;
   assign w_accept  = in_valid & in_ready;

   always_comb begin
      w_calc = '0;
      case (r_s1_sel)
         c_sel_add: w_calc = r_s1_a + r_s1_b;
         c_sel_sub: w_calc = r_s1_a - r_s1_b;
         c_sel_and: w_calc = r_s1_a & r_s1_b;
         default:   w_calc = r_s1_a | r_s1_b;
      endcase
   end

`ifdef ALU_RESP_FLAGS_EN
   logic w_cout;
   logic r_zero;
   logic r_carry;

   // Unsigned add wrapped iff the sum is below an operand; sub borrows iff a < b.
   always_comb begin
      w_cout = 1'b0;
      case (r_s1_sel)
         c_sel_add: w_cout = (w_calc < r_s1_a);
         c_sel_sub: w_cout = (r_s1_a < r_s1_b);
         default:   w_cout = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else if (w_xfer) begin
         r_zero  <= (w_calc == '0);
         r_carry <= w_cout;
      end
   end

   assign zero  = r_zero;
   assign carry = r_carry;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_sel   <= 2'b00;
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_op_count <= 32'd0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= op_a;
            r_s1_b     <= op_b;
            r_s1_sel   <= sel;
         end else if (w_xfer) begin
            r_s1_valid <= 1'b0;
         end

         if (w_xfer) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_calc;
         end else if (w_consume) begin
            r_s2_valid <= 1'b0;
         end

         if (w_consume) begin
            r_op_count <= r_op_count + 32'd1;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_result;
   assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_resp.sv
`default_nettype none
// Directed self-checking bench for alu_resp: arithmetic, back-pressure,
// asynchronous reset and op_count wrap.
module tb_alu_resp;

   localparam int N = 64;
   localparam logic [1:0] c_add = 2'b00;
   localparam logic [1:0] c_sub = 2'b01;
   localparam logic [1:0] c_and = 2'b10;
   localparam logic [1:0] c_or  = 2'b11;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic [1:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic [31:0]  op_count;
`ifdef ALU_RESP_FLAGS_EN
   logic         zero;
   logic         carry;
`endif

   int errors = 0;
   int checks = 0;

   alu_resp #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .op_count  (op_count)
`ifdef ALU_RESP_FLAGS_EN
      ,
      .zero      (zero),
      .carry     (carry)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
      in_valid = v;
      sel      = s;
      op_a     = a;
      op_b     = b;
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, c_add, '0, '0);
      tick();
      tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_result",    result, 64'd0);
      check("rst_op_count",  {32'd0, op_count}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
      rst = 1'b0;

      // ADD 5+3, latency two edges, then one consume
      out_ready = 1'b1;
      drive(1'b1, c_add, 64'd5, 64'd3);
      tick();
      drive(1'b0, c_add, '0, '0);
      check("add_lat_s1_only", {63'd0, out_valid}, 64'd0);
      tick();
      check("add_out_valid", {63'd0, out_valid}, 64'd1);
      check("add_result",    result, 64'd8);
      tick();
      check("add_op_count",  {32'd0, op_count}, 64'd1);
      check("add_drained",   {63'd0, out_valid}, 64'd0);

      // ADD wraps to zero with carry-out
      drive(1'b1, c_add, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      tick();
      drive(1'b0, c_add, '0, '0);
      tick();
      check("addwrap_result", result, 64'd0);
`ifdef ALU_RESP_FLAGS_EN
      check("addwrap_zero",  {63'd0, zero},  64'd1);
      check("addwrap_carry", {63'd0, carry}, 64'd1);
`endif

      // SUB 3-5 borrows; accepted while the previous result is consumed
      drive(1'b1, c_sub, 64'd3, 64'd5);
      tick();
      drive(1'b0, c_add, '0, '0);
      tick();
      check("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef ALU_RESP_FLAGS_EN
      check("sub_zero",  {63'd0, zero},  64'd0);
      check("sub_carry", {63'd0, carry}, 64'd1);
`endif
      tick();
      check("sub_op_count", {32'd0, op_count}, 64'd3);

      // Back-pressure: four requests, out_ready low for five cycles
      out_ready = 1'b0;
      drive(1'b1, c_and, 64'hF0, 64'h3C);
      check("bp_ready_1", {63'd0, in_ready}, 64'd1);
      tick();
      drive(1'b1, c_or, 64'hF0, 64'h0F);
      check("bp_ready_2", {63'd0, in_ready}, 64'd1);
      tick();
      drive(1'b1, c_add, 64'd1, 64'd1);
      check("bp_first_res", result, 64'h30);
      check("bp_ready_low", {63'd0, in_ready}, 64'd0);
      tick();
      tick();
      tick();
      check("bp_hold_valid",  {63'd0, out_valid}, 64'd1);
      check("bp_hold_result", result, 64'h30);
      check("bp_hold_ready",  {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {63'd0, in_ready}, 64'd1);
      tick();
      drive(1'b1, c_sub, 64'd9, 64'd4);
      check("bp_res_or", result, 64'hFF);
      tick();
      drive(1'b0, c_add, '0, '0);
      check("bp_res_add", result, 64'd2);
      tick();
      check("bp_res_sub",   result, 64'd5);
      check("bp_res_valid", {63'd0, out_valid}, 64'd1);
      tick();
      check("bp_empty",    {63'd0, out_valid}, 64'd0);
      check("bp_op_count", {32'd0, op_count}, 64'd7);

      // Reset asynchronously while S1 and S2 both hold requests
      out_ready = 1'b0;
      drive(1'b1, c_add, 64'd7, 64'd7);
      tick();
      drive(1'b1, c_or, 64'h1, 64'h2);
      tick();
      drive(1'b0, c_add, '0, '0);
      check("mid_full_valid", {63'd0, out_valid}, 64'd1);
      check("mid_full_ready", {63'd0, in_ready}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_result",    result, 64'd0);
      check("arst_op_count",  {32'd0, op_count}, 64'd0);
      check("arst_in_ready",  {63'd0, in_ready}, 64'd1);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
      check("post_rst_count",    {32'd0, op_count}, 64'd0);

      // op_count wrap: preload all-ones, then a single consume
      dut.r_op_count <= 32'hFFFF_FFFF;
      #1;
      check("wrap_preload", {32'd0, op_count}, 64'h0000_0000_FFFF_FFFF);
      drive(1'b1, c_and, 64'hFF00, 64'h0FF0);
      tick();
      drive(1'b0, c_add, '0, '0);
      tick();
      check("wrap_result", result, 64'h0F00);
      tick();
      check("wrap_op_count", {32'd0, op_count}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
